// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg -- shared definitions for the 4-digit seven-segment scanner.
//   * 4-bit display codes (ZERO, ONE, TWO, THREE, P, R, S, ERR, OFF) so that
//     any block producing display codes uses the same values.
//   * Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
//   * Anode constants and the scan FSM state type.
package seg_scan_pkg;

  // Display codes
  localparam logic [3:0] ZERO  = 4'h0;
  localparam logic [3:0] ONE   = 4'h1;
  localparam logic [3:0] TWO   = 4'h2;
  localparam logic [3:0] THREE = 4'h3;
  localparam logic [3:0] P     = 4'h4;
  localparam logic [3:0] R     = 4'h5;
  localparam logic [3:0] S     = 4'h6;
  localparam logic [3:0] ERR   = 4'h8;
  localparam logic [3:0] OFF   = 4'hF;

  // Active-low cathode patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {GHOST, SHOW} scan_state_e;

  // Active-low anode for a digit index; index 0 (leftmost digit) is an[3].
  function automatic logic [3:0] digit_anode(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if -- display bus of the scanner.
//   d1_in..d4_in : 4-bit display codes, digit 1 (leftmost) .. digit 4
//   blink        : blink request (only honoured when SEG_SCAN_BLINK_EN is defined)
//   seg          : active-low cathodes {g,f,e,d,c,b,a}
//   an           : active-low anodes, an[3] = digit 1, an[0] = digit 4
//   frame        : one-cycle pulse when a new input snapshot is taken
// master = code producer, slave = seg_scan.
interface seg_scan_if;
  logic [3:0] d1_in;
  logic [3:0] d2_in;
  logic [3:0] d3_in;
  logic [3:0] d4_in;
  logic       blink;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  modport master (output d1_in, d2_in, d3_in, d4_in, blink,
                  input  seg, an, frame);
  modport slave  (input  d1_in, d2_in, d3_in, d4_in, blink,
                  output seg, an, frame);
endinterface

// File: rtl/seg_decode.sv
// seg_decode -- purely combinational code-to-segment decoder.
//   code : 4-bit display code
//   pat  : 7-bit active-low pattern {g,f,e,d,c,b,a}; unlisted codes are blank.
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_BLANK;
    case (code)
      ZERO:    pat = SEG_ZERO;
      ONE:     pat = SEG_ONE;
      TWO:     pat = SEG_TWO;
      THREE:   pat = SEG_THREE;
      P:       pat = SEG_P;
      R:       pat = SEG_R;
      S:       pat = SEG_S;
      ERR:     pat = SEG_ERR;
      default: pat = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed driver for a 4-digit common-anode display.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (blanks the display immediately)
//   bus   : seg_scan_if.slave (codes and blink in; seg, an, frame out)
// Each digit owns a slot of REFRESH_DIV cycles; the first GHOST_CYC cycles of
// a slot keep every anode off to hide ghosting. All four codes are sampled
// together at the start of digit 1's slot, so a frame never mixes inputs.
// Optional feature macro: SEG_SCAN_BLINK_EN (phase toggles every BLINK_DIV
// cycles while blink=1; anodes are dark during the off phase).
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GHOST_CYC   = 2000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_LAST = CNT_W'(GHOST_CYC - 1);
  localparam scan_state_e      START_ST   = (GHOST_CYC > 0) ? GHOST : SHOW;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  scan_state_e      state;
  logic [3:0]       snap [4];
  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic             frame_q;

  logic             slot_end;
  logic             take;
  logic             dark;
  logic [3:0]       cur_code;
  logic [6:0]       cur_pat;

  assign slot_end = (cnt == SLOT_LAST);
  // First cycle of digit 1's slot: this is also the state right after reset.
  assign take     = (cnt == '0) && (idx == 2'd0);

  // While the snapshot is being taken, show the value being captured so a
  // zero-length ghost window cannot display the previous frame's digit 1.
  always_comb begin
    cur_code = snap[idx];
    if (take) cur_code = bus.d1_in;
  end

  seg_decode u_dec (
    .code (cur_code),
    .pat  (cur_pat)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic          blink_on;

  // Blink phase: counts only while blinking, parked in the on phase otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (!bus.blink) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt     <= '0;
      blink_on <= ~blink_on;
    end else begin
      bcnt     <= bcnt + BW'(1);
    end
  end

  assign dark = bus.blink & ~blink_on;
`else
  // blink and BLINK_DIV are deliberately left without function in this build.
  logic unused_blink;
  assign unused_blink = bus.blink ^ BLINK_DIV[0];
  assign dark         = 1'b0;
`endif

  // Counters, scan FSM, snapshot and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 2'd0;
      state   <= START_ST;
      snap    <= '{default: OFF};
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      frame_q <= take;
      if (take) snap <= '{bus.d1_in, bus.d2_in, bus.d3_in, bus.d4_in};

      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // state tracks the phase of the current cnt; outputs follow one cycle later
      case (state)
        GHOST: begin
          seg_q <= SEG_BLANK;
          an_q  <= AN_OFF;
          if (cnt == GHOST_LAST) state <= SHOW;
        end
        SHOW: begin
          seg_q <= cur_pat;
          an_q  <= dark ? AN_OFF : digit_anode(idx);
          if (slot_end && (GHOST_CYC != 0)) state <= GHOST;
        end
        default: state <= START_ST;
      endcase
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan -- self-checking bench for seg_scan (REFRESH_DIV=8,
// GHOST_CYC=2, BLINK_DIV=64). The reference model works from the cycle
// number since reset release: slot, digit and frame follow by division, and
// the displayed codes are the inputs present at the start of each frame.
module tb_seg_scan;

  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BD = 64;
  localparam int FR = 4 * RD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int         t = 0;          // clock edges since reset release
  logic [3:0] msnap [4] = '{4'hF, 4'hF, 4'hF, 4'hF};

  seg_scan_if bus ();

  seg_scan #(.REFRESH_DIV(RD), .GHOST_CYC(GC), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference timeline: a new frame starts every FR cycles after release.
  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0;
    end else begin
      if (t % FR == 0) msnap = '{bus.d1_in, bus.d2_in, bus.d3_in, bus.d4_in};
      t = t + 1;
    end
  end

  function automatic logic [6:0] ref_dec(input logic [3:0] c);
    case (c)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0001100;
      4'h5:    return 7'b0101111;
      4'h6:    return 7'b0010010;
      4'h8:    return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Outputs seen after edge t reflect the counter state of cycle t-1.
  function automatic logic [3:0] exp_an();
    int j;
    if (t == 0) return 4'hF;
    j = t - 1;
    if (j % RD < GC) return 4'hF;
    return 4'((~(4'b1000 >> ((j / RD) % 4))) & 4'hF);
  endfunction

  function automatic logic [6:0] exp_seg();
    int j;
    if (t == 0) return 7'h7F;
    j = t - 1;
    if (j % RD < GC) return 7'h7F;
    return ref_dec(msnap[(j / RD) % 4]);
  endfunction

  function automatic logic exp_frame();
    return (t > 0) && ((t - 1) % FR == 0);
  endfunction

  task automatic test_reset();
    bus.blink = 1'b0;
    bus.d1_in = 4'h0; bus.d2_in = 4'h0; bus.d3_in = 4'h0; bus.d4_in = 4'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL reset_an got=%b want=1111", bus.an); end
    checks++; if (bus.seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b want=1111111", bus.seg); end
    checks++; if (bus.frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b want=0", bus.frame); end
  endtask

  task automatic test_scan_pattern();
    int ghost_run = 0;
    logic [6:0] want;
    bus.d1_in = 4'b0100; bus.d2_in = 4'b0001; bus.d3_in = 4'b1111; bus.d4_in = 4'b0101;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      checks++; if (bus.an !== exp_an()) begin failures++; $display("FAIL scan_an t=%0d got=%b want=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin failures++; $display("FAIL scan_seg t=%0d got=%b want=%b", t, bus.seg, exp_seg()); end
      checks++; if (bus.frame !== exp_frame()) begin failures++; $display("FAIL scan_frame t=%0d got=%b want=%b", t, bus.frame, exp_frame()); end
      checks++; if ($countones(~bus.an) > 1) begin failures++; $display("FAIL scan_onehot t=%0d got=%b want=at_most_one_low", t, bus.an); end
      if (bus.an === 4'hF) begin
        ghost_run++;
      end else begin
        if (ghost_run != 0) begin
          checks++; if (ghost_run != GC) begin failures++; $display("FAIL ghost_len t=%0d got=%0d want=%0d", t, ghost_run, GC); end
        end
        ghost_run = 0;
        case (bus.an)
          4'b0111: want = 7'b0001100;
          4'b1011: want = 7'b1111001;
          4'b1101: want = 7'b1111111;
          4'b1110: want = 7'b0101111;
          default: want = 7'b0000000;
        endcase
        checks++; if (bus.seg !== want) begin failures++; $display("FAIL pattern_seg an=%b got=%b want=%b", bus.an, bus.seg, want); end
      end
    end
  endtask

  task automatic test_midframe_change();
    bit found = 0;
    bit after = 0;
    int n_old = 0;
    int n_new = 0;
    logic [6:0] want;
    for (int i = 0; i < 3 * FR && !found; i++) begin
      @(negedge clk);
      if (bus.an === 4'b1011) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midframe_wait got=timeout want=digit2"); return; end
    bus.d4_in = 4'b1000;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      if (bus.frame === 1'b1) after = 1;
      checks++; if (bus.an !== exp_an()) begin failures++; $display("FAIL midframe_an t=%0d got=%b want=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin failures++; $display("FAIL midframe_seg t=%0d got=%b want=%b", t, bus.seg, exp_seg()); end
      if (bus.an === 4'b1110) begin
        want = after ? 7'b0000110 : 7'b0101111;
        if (after) n_new++; else n_old++;
        checks++; if (bus.seg !== want) begin failures++; $display("FAIL midframe_d4 t=%0d got=%b want=%b", t, bus.seg, want); end
      end
    end
    checks++; if (n_old == 0 || n_new == 0) begin failures++; $display("FAIL midframe_cover got=%0d/%0d want=both_nonzero", n_old, n_new); end
  endtask

  task automatic test_unlisted();
    logic [3:0] pool [7];
    bit seen = 0;
    pool = '{4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    bus.d1_in = pool[$urandom_range(0, 6)]; bus.d2_in = pool[$urandom_range(0, 6)];
    bus.d3_in = pool[$urandom_range(0, 6)]; bus.d4_in = pool[$urandom_range(0, 6)];
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      if (bus.frame === 1'b1) seen = 1;
      checks++; if (bus.seg !== exp_seg()) begin failures++; $display("FAIL unlisted_model t=%0d got=%b want=%b", t, bus.seg, exp_seg()); end
      if (seen && bus.an !== 4'hF) begin
        checks++; if (bus.seg !== 7'h7F) begin failures++; $display("FAIL unlisted_blank t=%0d got=%b want=1111111", t, bus.seg); end
      end
      if (i % 3 == 0) begin
        bus.d1_in = pool[$urandom_range(0, 6)]; bus.d2_in = pool[$urandom_range(0, 6)];
        bus.d3_in = pool[$urandom_range(0, 6)]; bus.d4_in = pool[$urandom_range(0, 6)];
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FR; i++) begin
      @(negedge clk);
      checks++; if (bus.an !== exp_an()) begin failures++; $display("FAIL random_an t=%0d got=%b want=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin failures++; $display("FAIL random_seg t=%0d got=%b want=%b", t, bus.seg, exp_seg()); end
      checks++; if (bus.frame !== exp_frame()) begin failures++; $display("FAIL random_frame t=%0d got=%b want=%b", t, bus.frame, exp_frame()); end
      if ($urandom_range(0, 7) == 0) bus.d1_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.d2_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.d3_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.d4_in = 4'($urandom);
    end
  endtask

  task automatic test_reset_mid_show();
    bit found = 0;
    for (int i = 0; i < 3 * RD && !found; i++) begin
      @(negedge clk);
      if (bus.an !== 4'hF) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midreset_wait got=timeout want=show"); return; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL midreset_an got=%b want=1111", bus.an); end
    checks++; if (bus.seg !== 7'h7F) begin failures++; $display("FAIL midreset_seg got=%b want=1111111", bus.seg); end
    checks++; if (bus.frame !== 1'b0) begin failures++; $display("FAIL midreset_frame got=%b want=0", bus.frame); end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.frame !== 1'b1) begin failures++; $display("FAIL release_frame got=%b want=1", bus.frame); end
    checks++; if (bus.an !== 4'hF) begin failures++; $display("FAIL release_ghost got=%b want=1111", bus.an); end
    found = 0;
    for (int i = 0; i < RD && !found; i++) begin
      @(negedge clk);
      if (bus.an !== 4'hF) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL release_show got=timeout want=show"); end
    checks++; if (bus.an !== 4'b0111) begin failures++; $display("FAIL release_digit got=%b want=0111", bus.an); end
    checks++; if (t != GC + 1) begin failures++; $display("FAIL release_latency got=%0d want=%0d", t, GC + 1); end
  endtask

`ifdef SEG_SCAN_BLINK_EN
  task automatic test_blink();
    logic [3:0] want;
    int dark_n = 0;
    bus.blink = 1'b1;
    for (int nb = 1; nb <= 4 * BD; nb++) begin
      @(negedge clk);
      want = (((nb - 1) / BD) % 2 == 1) ? 4'hF : exp_an();
      if (want == 4'hF) dark_n++;
      checks++; if (bus.an !== want) begin failures++; $display("FAIL blink_an n=%0d got=%b want=%b", nb, bus.an, want); end
    end
    bus.blink = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      checks++; if (bus.an !== exp_an()) begin failures++; $display("FAIL noblink_an t=%0d got=%b want=%b", t, bus.an, exp_an()); end
    end
  endtask
`else
  task automatic test_blink_ignored();
    bus.blink = 1'b1;
    for (int i = 0; i < 5 * FR; i++) begin
      @(negedge clk);
      checks++; if (bus.an !== exp_an()) begin failures++; $display("FAIL blinkoff_an t=%0d got=%b want=%b", t, bus.an, exp_an()); end
      checks++; if (bus.seg !== exp_seg()) begin failures++; $display("FAIL blinkoff_seg t=%0d got=%b want=%b", t, bus.seg, exp_seg()); end
    end
    bus.blink = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan_pattern();
    test_midframe_change();
    test_unlisted();
    test_random();
    test_reset_mid_show();
`ifdef SEG_SCAN_BLINK_EN
    test_blink();
`else
    test_blink_ignored();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
